// File: rtl/memory_hub.sv
// memory_hub: bridges a BUS_BYTES-wide request bus onto NUM_TGT byte-serial memory targets; MEMORY_HUB_TIMEOUT_EN adds a per-byte timeout.
// Latency: 2 cycles per byte plus target latency, then a 1-cycle RESP pulse (i_bhw=0 or bad i_bhw answers 2 cycles after accept).
// Backpressure: none; requests are taken only in IDLE, i_bus_DV while busy is dropped, targets pace bytes via i_tgt_done.
module memory_hub #(
    parameter int BUS_BYTES   = 4,
    parameter int NUM_TGT     = 2,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [8*BUS_BYTES-1:0]       i_bus_data,
    input  logic [ADDR_W-1:0]            i_bus_address,
    input  logic                         i_bus_DV,
    input  logic [$clog2(BUS_BYTES):0]   i_bhw,
    input  logic                         i_write_notread,
    output logic [8*BUS_BYTES-1:0]       o_bus_data,
    output logic                         o_bus_DV,
    output logic                         o_bus_err,
    output logic                         o_busy,
    output logic [NUM_TGT-1:0]           o_tgt_request,
    output logic                         o_tgt_write,
    output logic [ADDR_W-1:0]            o_tgt_address,
    output logic [7:0]                   o_tgt_data,
    input  logic [NUM_TGT-1:0]           i_tgt_sel,
    input  logic [8*NUM_TGT-1:0]         i_tgt_data,
    input  logic [NUM_TGT-1:0]           i_tgt_done
);

    localparam int CW = $clog2(BUS_BYTES) + 1;
    localparam int DW = 8 * BUS_BYTES;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state, state_nx;
    logic [DW-1:0]       wdata_q, rdata_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [CW-1:0]       bhw_q, cnt_q, cnt_inc;
    logic                wr_q, err_q, err_nx;
    logic [NUM_TGT-1:0]  sel_q, req;
    logic                accept, take_byte, sel_onehot, done_sel, timed_out;
    logic [7:0]          rd_byte, wr_byte;

    assign accept     = (state == IDLE) && i_bus_DV;
    assign cnt_inc    = cnt_q + CW'(1);
    assign sel_onehot = (i_tgt_sel != '0) && ((i_tgt_sel & (i_tgt_sel - NUM_TGT'(1))) == '0);
    assign done_sel   = |(i_tgt_done & sel_q);

    always_comb begin
        rd_byte = '0;
        for (int t = 0; t < NUM_TGT; t++) begin
            if (sel_q[t]) rd_byte = rd_byte | i_tgt_data[8*t +: 8];
        end
    end

    always_comb begin
        wr_byte = '0;
        for (int k = 0; k < BUS_BYTES; k++) begin
            if (cnt_q == CW'(k)) wr_byte = wdata_q[8*k +: 8];
        end
    end

`ifdef MEMORY_HUB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_q;

    // Cleared while issuing so every byte gets a fresh TIMEOUT_CYC budget in WAIT.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tmo_q <= '0;
        end else if (state == ISSUE) begin
            tmo_q <= '0;
        end else if (state == WAIT) begin
            tmo_q <= tmo_q + TW'(1);
        end
    end

    assign timed_out = (tmo_q == TW'(TIMEOUT_CYC - 1));
`else
    assign timed_out = (TIMEOUT_CYC < 0);
`endif

    // Size checks live in ISSUE so that degenerate requests still take one pass through the FSM.
    always_comb begin
        state_nx  = state;
        err_nx    = err_q;
        req       = '0;
        take_byte = 1'b0;
        case (state)
            IDLE: begin
                if (i_bus_DV) begin
                    state_nx = ISSUE;
                    err_nx   = 1'b0;
                end
            end
            ISSUE: begin
                if (bhw_q == '0) begin
                    state_nx = RESP;
                end else if (bhw_q > CW'(BUS_BYTES)) begin
                    state_nx = RESP;
                    err_nx   = 1'b1;
                end else if (sel_onehot) begin
                    req      = i_tgt_sel;
                    state_nx = WAIT;
                end else begin
                    state_nx = RESP;
                    err_nx   = 1'b1;
                end
            end
            WAIT: begin
                if (done_sel) begin
                    take_byte = 1'b1;
                    state_nx  = (cnt_inc == bhw_q) ? RESP : ISSUE;
                end else if (timed_out) begin
                    state_nx = RESP;
                    err_nx   = 1'b1;
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            err_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
            bhw_q   <= '0;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            sel_q   <= '0;
        end else begin
            state <= state_nx;
            err_q <= err_nx;
            if (accept) begin
                wdata_q <= i_bus_data;
                rdata_q <= i_write_notread ? i_bus_data : '0;
                addr_q  <= i_bus_address;
                bhw_q   <= i_bhw;
                wr_q    <= i_write_notread;
                cnt_q   <= '0;
                sel_q   <= '0;
            end
            if (req != '0) begin
                sel_q <= i_tgt_sel;
            end
            if (take_byte) begin
                cnt_q  <= cnt_inc;
                addr_q <= addr_q + ADDR_W'(1);
                if (!wr_q) begin
                    for (int k = 0; k < BUS_BYTES; k++) begin
                        if (cnt_q == CW'(k)) rdata_q[8*k +: 8] <= rd_byte;
                    end
                end
            end
        end
    end

    assign o_bus_data    = rdata_q;
    assign o_bus_DV      = (state == RESP);
    assign o_bus_err     = (state == RESP) && err_q;
    assign o_busy        = (state != IDLE);
    assign o_tgt_request = req;
    assign o_tgt_write   = wr_q;
    assign o_tgt_address = addr_q;
    assign o_tgt_data    = wr_byte;

endmodule
